// File: rtl/fetch_queue.sv
// Sequential instruction fetch front-end: issues word fetches, tags responses with their PC, buffers
// them in a FIFO and flushes on redirect. Define FETCH_STATS_EN to add the stall/flush/error outputs.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic [31:0] fetch_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count,
    output logic [0:0]  rsp_error
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    logic [CW-1:0] count_q, outst_q, drop_q;
    logic [AW-1:0] wr_ptr, rd_ptr, tag_wr, tag_rd;
    logic [31:0]   pc_q;
    logic [31:0]   fifo_data [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   tag_mem   [DEPTH];

    logic req_fire, rsp_take, rsp_drop, rsp_push, pop;

    // Credit covers both buffered entries and requests still in flight, so the FIFO never overflows.
    assign mem_req_valid = !reset && !redirect_valid &&
                           (({1'b0, count_q} + {1'b0, outst_q}) < LIMIT);
    assign mem_req_addr  = pc_q;
    assign fetch_pc      = pc_q;

    assign req_fire = mem_req_valid && mem_req_ready;
    assign rsp_take = mem_rsp_valid && (outst_q != '0);
    assign rsp_drop = rsp_take && (redirect_valid || (drop_q != '0));
    assign rsp_push = rsp_take && !rsp_drop;

    assign inst_valid = (count_q != '0);
    assign inst_data  = inst_valid ? fifo_data[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : '0;
    assign pop        = inst_valid && inst_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
            outst_q <= '0;
            drop_q  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_wr  <= '0;
            tag_rd  <= '0;
        end else begin
            outst_q <= outst_q + CW'(req_fire) - CW'(rsp_take);
            if (redirect_valid) begin
                // Everything still in flight after this edge belongs to the old path.
                pc_q    <= {redirect_pc[31:2], 2'b00};
                drop_q  <= outst_q - CW'(rsp_take);
                count_q <= '0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                tag_wr  <= '0;
                tag_rd  <= '0;
            end else begin
                if (req_fire) begin
                    pc_q   <= pc_q + 32'd4;
                    tag_wr <= tag_wr + 1'b1;
                end
                if (rsp_drop)
                    drop_q <= drop_q - 1'b1;
                if (rsp_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    tag_rd <= tag_rd + 1'b1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count_q <= count_q + CW'(rsp_push) - CW'(pop);
            end
        end
    end

    // Storage needs no reset: pointers and count decide what is visible.
    always_ff @(posedge clock) begin
        if (req_fire)
            tag_mem[tag_wr] <= pc_q;
        if (rsp_push) begin
            fifo_data[wr_ptr] <= mem_rsp_data;
            fifo_pc[wr_ptr]   <= tag_mem[tag_rd];
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
            rsp_error    <= '0;
        end else begin
            if (!inst_valid && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 32'd1;
            if (redirect_valid && (flush_count != '1))
                flush_count <= flush_count + 16'd1;
            if (mem_rsp_valid && (outst_q == '0))
                rsp_error <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: randomized memory/core traffic checked against a queue-based reference
// model, plus directed scenarios (latency, full, redirect, wrap, optional FETCH_STATS_EN outputs).
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        mem_req_valid, mem_req_ready, mem_rsp_valid, redirect_valid;
    logic [31:0] mem_req_addr, mem_rsp_data, redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data, inst_pc, fetch_pc;

    logic        w_req_valid, w_req_ready, w_rsp_valid, w_redirect_valid;
    logic [31:0] w_req_addr, w_rsp_data, w_redirect_pc;
    logic        w_inst_valid, w_inst_ready;
    logic [31:0] w_inst_data, w_inst_pc, w_fetch_pc;

`ifdef FETCH_STATS_EN
    logic [31:0] stall_cycles, w_stall_cycles;
    logic [15:0] flush_count, w_flush_count;
    logic [0:0]  rsp_error, w_rsp_error;
`endif

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
        .fetch_pc(fetch_pc)
`ifdef FETCH_STATS_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count), .rsp_error(rsp_error)
`endif
    );

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clock(clock), .reset(reset),
        .mem_req_valid(w_req_valid), .mem_req_ready(w_req_ready), .mem_req_addr(w_req_addr),
        .mem_rsp_valid(w_rsp_valid), .mem_rsp_data(w_rsp_data),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .inst_valid(w_inst_valid), .inst_ready(w_inst_ready), .inst_data(w_inst_data),
        .inst_pc(w_inst_pc), .fetch_pc(w_fetch_pc)
`ifdef FETCH_STATS_EN
        , .stall_cycles(w_stall_cycles), .flush_count(w_flush_count), .rsp_error(w_rsp_error)
`endif
    );

    // Reference model: requests in flight (with a live flag) and instructions awaiting delivery.
    typedef struct { logic [31:0] addr; logic [31:0] data; int due; bit live; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ins_t;
    req_t        memq[$];
    ins_t        instq[$];
    logic [31:0] exp_pc;

    int n_tests = 0, n_fail = 0, cyc = 0;
    int lat_min = 1, lat_max = 1, rdy_pct = 100, irdy_pct = 100, rsp_pct = 100;
    bit data_is_addr = 1'b1;

    bit          obs_fire, obs_req_valid, obs_inst_valid, obs_rsp;
    logic [31:0] obs_addr, obs_inst_pc;
    int          n_fire, n_pop, first_fire, first_inst;
    logic [31:0] first_inst_pc;

    task automatic do_reset();
        reset = 1'b1;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
        redirect_valid = 0; redirect_pc = 0; inst_ready = 0;
        w_req_ready = 0; w_rsp_valid = 0; w_rsp_data = 0;
        w_redirect_valid = 0; w_redirect_pc = 0; w_inst_ready = 0;
        @(negedge clock);
        n_tests++;
        if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0 || w_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valids: req=%b inst=%b wreq=%b want 0", mem_req_valid, inst_valid, w_req_valid);
        end
        n_tests++;
        if (inst_data !== 32'h0 || inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_inst: data=%h pc=%h want 0", inst_data, inst_pc);
        end
        n_tests++;
        if (fetch_pc !== 32'h0 || w_fetch_pc !== 32'hFFFF_FFF8) begin
            n_fail++;
            $display("FAIL reset_pc: %h/%h want 00000000/fffffff8", fetch_pc, w_fetch_pc);
        end
`ifdef FETCH_STATS_EN
        n_tests++;
        if (stall_cycles !== 32'd0 || flush_count !== 16'd0 || rsp_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stats: %0d %0d %b want 0", stall_cycles, flush_count, rsp_error);
        end
`endif
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        memq.delete(); instq.delete();
        exp_pc = 32'h0; cyc = 0; n_fire = 0; n_pop = 0; first_fire = -1; first_inst = -1;
    endtask

    // One clock cycle of randomized memory/core behaviour, checked against the model.
    task automatic step(input bit rd, input logic [31:0] rpc);
        bit exp_rv, exp_iv, fire, pop, rsp;
        req_t e;
        ins_t h;
        redirect_valid = rd;
        redirect_pc    = rpc;
        mem_req_ready  = (int'($urandom_range(99, 0)) < rdy_pct);
        inst_ready     = (int'($urandom_range(99, 0)) < irdy_pct);
        rsp = (memq.size() != 0) && (memq[0].due <= cyc) && (int'($urandom_range(99, 0)) < rsp_pct);
        mem_rsp_valid  = rsp;
        mem_rsp_data   = rsp ? memq[0].data : $urandom;
        @(negedge clock);
        exp_rv = !rd && ((instq.size() + memq.size()) < DEPTH);
        exp_iv = (instq.size() != 0);
        n_tests++;
        if (mem_req_valid !== exp_rv) begin
            n_fail++;
            $display("FAIL req_valid cyc%0d: got %b want %b", cyc, mem_req_valid, exp_rv);
        end
        n_tests++;
        if (fetch_pc !== exp_pc) begin
            n_fail++;
            $display("FAIL fetch_pc cyc%0d: got %h want %h", cyc, fetch_pc, exp_pc);
        end
        if (exp_rv) begin
            n_tests++;
            if (mem_req_addr !== exp_pc) begin
                n_fail++;
                $display("FAIL req_addr cyc%0d: got %h want %h", cyc, mem_req_addr, exp_pc);
            end
        end
        n_tests++;
        if (inst_valid !== exp_iv) begin
            n_fail++;
            $display("FAIL inst_valid cyc%0d: got %b want %b", cyc, inst_valid, exp_iv);
        end
        if (exp_iv) begin
            n_tests++;
            if (inst_pc !== instq[0].pc || inst_data !== instq[0].data) begin
                n_fail++;
                $display("FAIL inst cyc%0d: got pc=%h data=%h want pc=%h data=%h",
                         cyc, inst_pc, inst_data, instq[0].pc, instq[0].data);
            end
        end
        obs_req_valid  = mem_req_valid;
        obs_fire       = mem_req_valid && mem_req_ready;
        obs_addr       = mem_req_addr;
        obs_inst_valid = inst_valid;
        obs_inst_pc    = inst_pc;
        obs_rsp        = rsp;
        if (obs_fire) n_fire++;
        if (inst_valid && inst_ready) n_pop++;
        if (first_fire < 0 && obs_fire) first_fire = cyc;
        if (first_inst < 0 && inst_valid) begin
            first_inst    = cyc;
            first_inst_pc = inst_pc;
        end

        fire = exp_rv && mem_req_ready;
        pop  = exp_iv && inst_ready;
        if (pop) h = instq.pop_front();
        if (rsp) begin
            e = memq.pop_front();
            if (e.live && !rd) instq.push_back('{pc: e.addr, data: e.data});
        end
        if (fire) begin
            e.addr = exp_pc;
            e.data = data_is_addr ? exp_pc : $urandom;
            e.due  = cyc + int'($urandom_range(lat_max, lat_min));
            e.live = 1'b1;
            memq.push_back(e);
            exp_pc = exp_pc + 32'd4;
        end
        if (rd) begin
            foreach (memq[i]) memq[i].live = 1'b0;
            instq.delete();
            exp_pc = {rpc[31:2], 2'b00};
        end
        cyc++;
        @(posedge clock); #1;
    endtask

    task automatic set_knobs(input int lmin, input int lmax, input int rdy, input int irdy, input int rspp);
        lat_min = lmin; lat_max = lmax; rdy_pct = rdy; irdy_pct = irdy; rsp_pct = rspp;
    endtask

    task automatic test_sequential();
        do_reset();
        set_knobs(1, 1, 100, 100, 100);
        data_is_addr = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0);
        n_tests++;
        if (first_inst - first_fire != 2 || first_inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL seq_latency: fire@%0d inst@%0d pc=%h want +2 pc=0", first_fire, first_inst, first_inst_pc);
        end
        n_tests++;
        if (n_pop != 18) begin
            n_fail++;
            $display("FAIL seq_throughput: got %0d pops want 18", n_pop);
        end
    endtask

    task automatic test_full();
        do_reset();
        set_knobs(1, 1, 100, 0, 100);
        data_is_addr = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0);
        n_tests++;
        if (n_fire != 4 || obs_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_stop: got %0d fires valid=%b want 4 valid=0", n_fire, obs_req_valid);
        end
        irdy_pct = 100;
        step(1'b0, 32'h0);
        irdy_pct = 0;
        step(1'b0, 32'h0);
        n_tests++;
        if (!obs_fire || obs_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL full_resume: fire=%b addr=%h want 1 00000010", obs_fire, obs_addr);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0);
        n_tests++;
        if (n_fire != 5) begin
            n_fail++;
            $display("FAIL full_hold: got %0d fires want 5", n_fire);
        end
        irdy_pct = 100;
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0);
    endtask

    task automatic test_redirect_stale();
        bit          stale = 1'b0;
        int          first_pc_seen = 0, first_addr_seen = 0;
        logic [31:0] fpc = 32'hX, faddr = 32'hX;
        do_reset();
        set_knobs(3, 3, 100, 0, 100);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0);
        step(1'b1, 32'h103);
        irdy_pct = 100;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 32'h0);
            if (obs_inst_valid && obs_inst_pc < 32'h100) stale = 1'b1;
            if (obs_inst_valid && first_pc_seen == 0) begin fpc = obs_inst_pc; first_pc_seen = 1; end
            if (obs_fire && first_addr_seen == 0) begin faddr = obs_addr; first_addr_seen = 1; end
        end
        n_tests++;
        if (stale || fpc !== 32'h100 || faddr !== 32'h100) begin
            n_fail++;
            $display("FAIL redirect_stale: stale=%b first_pc=%h first_addr=%h want 0 100 100", stale, fpc, faddr);
        end
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        set_knobs(1, 1, 100, 100, 100);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0);
        step(1'b1, 32'h200);
        n_tests++;
        if (!obs_inst_valid || !obs_rsp) begin
            n_fail++;
            $display("FAIL same_cycle_setup: inst_valid=%b rsp=%b want 1 1", obs_inst_valid, obs_rsp);
        end
        step(1'b0, 32'h0);
        n_tests++;
        if (obs_inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle_flush: inst_valid=%b want 0", obs_inst_valid);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_knobs(3, 3, 100, 100, 100);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0);
        step(1'b1, 32'h300);
        step(1'b1, 32'h402);
        first_inst = -1;
        for (int i = 0; i < 15; i++) step(1'b0, 32'h0);
        n_tests++;
        if (first_inst_pc !== 32'h400) begin
            n_fail++;
            $display("FAIL back_to_back: first pc=%h want 00000400", first_inst_pc);
        end
    endtask

    task automatic test_wrap();
        bit          prev_fire = 1'b0;
        logic [31:0] prev_addr = 32'h0, base = 32'hFFFF_FFF8, exp_a;
        int          nf = 0, ni = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            w_req_ready  = 1'b1;
            w_inst_ready = 1'b1;
            w_rsp_valid  = prev_fire;
            w_rsp_data   = prev_addr ^ 32'h5A5A_5A5A;
            @(negedge clock);
            prev_fire = w_req_valid;
            prev_addr = w_req_addr;
            if (w_req_valid) begin
                exp_a = base + 32'(nf * 4);
                n_tests++;
                if (w_req_addr !== exp_a) begin
                    n_fail++;
                    $display("FAIL wrap_addr: got %h want %h", w_req_addr, exp_a);
                end
                nf++;
            end
            if (w_inst_valid) begin
                exp_a = base + 32'(ni * 4);
                n_tests++;
                if (w_inst_pc !== exp_a || w_inst_data !== (exp_a ^ 32'h5A5A_5A5A)) begin
                    n_fail++;
                    $display("FAIL wrap_inst: pc=%h data=%h want pc=%h", w_inst_pc, w_inst_data, exp_a);
                end
                ni++;
            end
            @(posedge clock); #1;
        end
        n_tests++;
        if (nf < 3 || ni < 3) begin
            n_fail++;
            $display("FAIL wrap_count: reqs=%0d insts=%0d want >=3", nf, ni);
        end
        w_req_ready = 1'b0; w_rsp_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        bit          rd;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            set_knobs(1, int'($urandom_range(4, 1)), int'($urandom_range(100, 30)),
                      int'($urandom_range(100, 20)), int'($urandom_range(100, 50)));
            data_is_addr = 1'b0;
            for (int i = 0; i < 600; i++) begin
                rd  = (int'($urandom_range(99, 0)) < 3);
                rpc = $urandom;
                if (rpc[4]) rpc[31:8] = 24'hFFFFFF;
                step(rd, rpc);
            end
        end
    endtask

`ifdef FETCH_STATS_EN
    task automatic test_stats();
        do_reset();
        mem_rsp_valid = 1'b1;
        @(posedge clock); #1;
        mem_rsp_valid = 1'b0;
        @(negedge clock);
        n_tests++;
        if (rsp_error !== 1'b1 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stats_error: rsp_error=%b inst_valid=%b want 1 0", rsp_error, inst_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        @(posedge clock); @(posedge clock); #1;
        redirect_valid = 1'b0;
        @(negedge clock);
        n_tests++;
        if (flush_count !== 16'd2 || stall_cycles !== 32'd3) begin
            n_fail++;
            $display("FAIL stats_counts: flush=%0d stall=%0d want 2 3", flush_count, stall_cycles);
        end
        @(posedge clock); #1;
    endtask
`endif

    initial begin
        #1;
        test_sequential();
        test_full();
        test_redirect_stale();
        test_redirect_same_cycle();
        test_back_to_back();
        test_wrap();
        test_random();
`ifdef FETCH_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch front-end that sits directly upstream of the MIPS core's decode and execute datapath.
- Generates sequential word-aligned fetch addresses and issues them to a variable-latency instruction memory over a valid/ready request port with in-order responses.
- Buffers returned instructions, tagged with their PC, in a small FIFO and delivers them to the core over a valid/ready handshake.
- The core redirects fetch on taken branch, J, JAL or JR through a single-cycle redirect strobe, which flushes all in-flight and buffered instructions.

Parameters:
- DEPTH, 4, FIFO entries and also the maximum of (buffered + outstanding) requests; power of two, 2..16.
- RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_req_addr  out  32  fetch byte address, bits [1:0] always 0.
- mem_rsp_valid  in  1  response data valid; responses return in request order, with latency of at least 1 cycle.
- mem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  single-cycle strobe: flush and restart fetch.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored and forced to 0.
- inst_valid  out  1  instruction available to the core.
- inst_ready  in  1  core consumes the instruction this cycle.
- inst_data  out  32  instruction word at the FIFO head.
- inst_pc  out  32  PC of inst_data.
- fetch_pc  out  32  next address to request (debug).

Behaviour:
- Reset values:
  - fetch_pc = RESET_PC.
  - FIFO empty; inst_valid = 0; inst_data = 0; inst_pc = 0.
  - outstanding = 0; drop = 0.
  - mem_req_valid = 0 while reset is asserted.
- Reset asserted mid-operation discards everything immediately. Responses to pre-reset requests that arrive after reset are ignored only through the drop mechanism when a redirect is in progress. The memory is required to be reset together with this block.
- Request issue:
  - mem_req_valid = !redirect_valid && (count + outstanding < DEPTH).
  - The signal is combinational from registered state and redirect_valid.
  - mem_req_addr = fetch_pc.
  - On a handshake (valid && ready): fetch_pc += 4, wrapping modulo 2^32 (32'hFFFFFFFC -> 0); outstanding += 1.
  - mem_req_addr stays stable while valid is high and unaccepted, except when a redirect withdraws the request.
- PC tag queue: each accepted request pushes its address into an internal tag queue of DEPTH entries. Each non-dropped response pops the tag queue and pairs the tag with the data.
- Response handling:
  - When mem_rsp_valid arrives and drop > 0: drop -= 1, outstanding -= 1, data discarded.
  - Otherwise the response is written to the FIFO with its tag and outstanding -= 1.
  - Credit accounting guarantees no overflow.
  - A response with outstanding == 0 is ignored.
- Delivery:
  - inst_valid = (count != 0); inst_data and inst_pc come from the FIFO head.
  - The FIFO pops on inst_valid && inst_ready.
  - Latency: a response enqueued at edge N is visible at the head after edge N, so it is consumable in cycle N+1. There is no combinational bypass from mem_rsp to inst.
  - Push and pop in the same cycle leave count unchanged.
- Redirect (redirect_valid = 1 in cycle R):
  - At edge R: FIFO and tag queue cleared (count = 0); fetch_pc = {redirect_pc[31:2], 2'b00}.
  - drop = outstanding minus (1 if a response arrives in R), so every in-flight response is discarded.
  - A response arriving in cycle R is discarded.
  - A pop in cycle R is still a valid consumption; the core redirects only after consuming its instruction.
  - mem_req_valid = 0 in cycle R, so no request is accepted during a redirect.
  - Requests resume in R+1 at the new address.
  - Back-to-back redirects: the last one wins, and drop accumulates correctly.
- Full: when count + outstanding == DEPTH, mem_req_valid = 0. It reasserts in the cycle after a pop or a dropped response frees credit.

Optional Feature:
- FETCH_STATS_EN: defining this macro adds three outputs:
  - stall_cycles [31:0]: counts cycles with inst_valid == 0 while not in reset.
  - flush_count [15:0]: counts redirects.
  - rsp_error [0:0]: sticky; set by a response with outstanding == 0.
- All three reset to 0. stall_cycles and flush_count saturate.
- Without the macro, these ports and their logic are absent and stray responses are silently ignored.

Test Plan:
- Reset release, mem_req_ready = 1, 1-cycle latency memory returning word = addr, inst_ready = 1 -> requests 0x0, 0x4, 0x8... on consecutive cycles; first inst_valid 2 cycles after the first handshake with inst_pc = 0x0, inst_data = 0x0; afterwards one instruction per cycle.
- inst_ready = 0, DEPTH = 4 -> exactly 4 handshakes (0x0..0xC), then mem_req_valid = 0; one pop -> request 0x10 issued the next cycle; no data lost or duplicated.
- Memory latency 3 with 3 requests outstanding, redirect_pc = 0x103 -> the 3 stale responses are never visible on inst; next request is 0x100; first delivered inst_pc = 0x100.
- Redirect in the same cycle as a response and a pop -> the popped instruction counts as consumed, the response is dropped, and count = 0 after the edge.
- RESET_PC = 32'hFFFFFFF8 -> requests FFFFFFF8, FFFFFFFC, 00000000 with matching inst_pc tags.
- With FETCH_STATS_EN: a spurious mem_rsp_valid when idle -> rsp_error = 1 and inst_valid stays 0; 2 redirects -> flush_count = 2.
